// File: rtl/networkadapter_conf_wbif.sv
// Wishbone B3 slave front-end for the network adapter configuration register file.
// Classic cycles and incrementing bursts (linear / wrap-4/8/16) with registered ack/err/data.
module networkadapter_conf_wbif #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [2:0]            wb_cti_i,
   input  logic [1:0]            wb_bte_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  wb_rty_o,
   output logic [15:0]           conf_adr,
   output logic                  conf_we,
   output logic [31:0]           conf_data_i,
   input  logic [31:0]           conf_data,
   input  logic                  conf_ack,
   input  logic                  conf_err
);

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t      r_state, w_nxt;
   logic [15:0] r_burst_adr, w_nxt_badr, w_step;
   logic [31:0] r_dat;
   logic        r_ack, r_err;
   logic        w_req, w_bad, w_beat;
   logic        w_unused;

   // Upper address bits are decoded upstream; conf_ack is implied by ~conf_err.
   assign w_unused = ^{wb_adr_i[ADDR_WIDTH-1:16], conf_ack};

   function automatic logic [15:0] f_next(input logic [15:0] a, input logic [1:0] bte);
      case (bte)
         2'b00:   f_next = a + 16'd4;
         2'b01:   f_next = {a[15:4], a[3:2] + 2'd1, a[1:0]};
         2'b10:   f_next = {a[15:5], a[4:2] + 3'd1, a[1:0]};
         default: f_next = {a[15:6], a[5:2] + 4'd1, a[1:0]};
      endcase
   endfunction

   assign w_req       = wb_cyc_i & wb_stb_i;
   assign w_bad       = conf_err | (wb_we_i & (wb_sel_i != 4'hf));
   assign w_beat      = w_req & ((r_state == IDLE) | (r_state == BURST));
   assign conf_adr    = (r_state == BURST) ? r_burst_adr : wb_adr_i[15:0];
   assign conf_data_i = wb_dat_i;
   assign conf_we     = w_beat & wb_we_i & ~w_bad;
   assign w_step      = f_next(conf_adr, wb_bte_i);

   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign wb_rty_o = 1'b0;

   always_comb begin
      w_nxt      = r_state;
      w_nxt_badr = r_burst_adr;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (wb_cti_i == 3'b010 && !w_bad) begin
                  w_nxt      = BURST;
                  w_nxt_badr = w_step;
               end else begin
                  w_nxt = DONE;
               end
            end
         end
         BURST: begin
            if (!wb_cyc_i) begin
               w_nxt = IDLE;
            end else if (w_req) begin
               if (wb_cti_i == 3'b111 || w_bad) w_nxt = DONE;
               else                            w_nxt_badr = w_step;
            end
         end
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_burst_adr <= 16'h0;
         r_dat       <= 32'h0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_burst_adr <= w_nxt_badr;
         r_ack       <= w_beat & ~w_bad;
         r_err       <= w_beat & w_bad;
         if (w_beat) r_dat <= conf_data;
      end
   end

endmodule

// File: tb/tb_networkadapter_conf_wbif.sv
// Self-checking bench for networkadapter_conf_wbif: classic vector table, burst sequences, reset mid-burst.
module tb_networkadapter_conf_wbif;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dati = '0;
   logic [3:0]  sel = '0;
   logic [2:0]  cti = '0;
   logic [1:0]  bte = '0;
   logic [31:0] dato, cdi, cdat;
   logic        ack, err, rty, cwe, cack, cerr;
   logic [15:0] cadr;

   always #5 clk = ~clk;

   networkadapter_conf_wbif #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dati),
      .wb_sel_i(sel), .wb_cti_i(cti), .wb_bte_i(bte),
      .wb_dat_o(dato), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
      .conf_adr(cadr), .conf_we(cwe), .conf_data_i(cdi),
      .conf_data(cdat), .conf_ack(cack), .conf_err(cerr)
   );

   // Register file model: 0x1xxx is unmapped, read data is a fingerprint of the address.
   assign cerr = (cadr[15:12] == 4'h1);
   assign cack = ~cerr;
   assign cdat = {16'h0, cadr} ^ 32'h14;

   typedef struct packed {logic ack; logic err; logic [31:0] dat;} rsp_t;
   typedef struct {
      logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel;
      logic ack; logic err; logic [31:0] rd; int nwr;
   } vec_t;

   rsp_t        exp_q[$];
   vec_t        v[8];
   logic [15:0] ea[4];
   int          tests = 0, fails = 0;
   int          nwr = 0;
   logic [15:0] wadr = '0;
   logic [31:0] wdat = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) if (rst && cwe) begin
      nwr  <= nwr + 1;
      wadr <= cadr;
      wdat <= cdi;
   end

   // Scoreboard: every ack/err cycle must match the next expected response.
   always @(negedge clk) begin
      rsp_t e;
      if (rst && (ack || err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {30'h0, ack, err}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_ack", {31'h0, ack}, {31'h0, e.ack});
            chk("rsp_err", {31'h0, err}, {31'h0, e.err});
            chk("rsp_dat", dato, e.dat);
         end
      end
   end

   task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic eack, input logic eerr, input logic [31:0] erd, input int enwr);
      int n0;
      n0 = nwr;
      cyc = 1; stb = 1; we = w; adr = a; dati = d; sel = s; cti = 3'b000; bte = 2'b00;
      exp_q.push_back(rsp_t'{eack, eerr, erd});
      #1 chk("classic_conf_adr", {16'h0, cadr}, {16'h0, a[15:0]});
      @(posedge clk); #1;
      chk("done_no_we", {31'h0, cwe}, 32'h0);
      @(posedge clk); #1;
      cyc = 0; stb = 0; we = 0;
      chk("classic_nwr", nwr - n0, enwr);
      if (enwr > 0) begin
         chk("wr_adr", {16'h0, wadr}, {16'h0, a[15:0]});
         chk("wr_dat", wdat, d);
      end
      @(posedge clk); #1;
   endtask

   // Read burst over ea[0..n-1]; optional stb-low wait after beat index wait_after.
   task automatic burst(input logic [1:0] b, input int n, input int wait_after);
      for (int i = 0; i < n; i++) begin
         cyc = 1; stb = 1; we = 0; sel = 4'hf; bte = b;
         cti = (i == n - 1) ? 3'b111 : 3'b010;
         adr = {16'h0, ea[i]};
         exp_q.push_back(rsp_t'{1'b1, 1'b0, {16'h0, ea[i]} ^ 32'h14});
         #1 chk("burst_conf_adr", {16'h0, cadr}, {16'h0, ea[i]});
         @(posedge clk); #1;
         if (i == wait_after) begin
            stb = 0;
            #1 chk("wait_conf_adr", {16'h0, cadr}, {16'h0, ea[i+1]});
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      cyc = 0; stb = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      v[0] = '{1'b0, 32'h0000_0004, 32'h0,         4'hf, 1'b1, 1'b0, 32'h0000_0010, 0};
      v[1] = '{1'b1, 32'h0000_0108, 32'h5,         4'hf, 1'b1, 1'b0, 32'h0000_011C, 1};
      v[2] = '{1'b1, 32'h0000_0010, 32'h77,        4'h3, 1'b0, 1'b1, 32'h0000_0004, 0};
      v[3] = '{1'b0, 32'h0000_1000, 32'h0,         4'hf, 1'b0, 1'b1, 32'h0000_1014, 0};
      v[4] = '{1'b0, 32'hFFFF_0020, 32'h0,         4'hf, 1'b1, 1'b0, 32'h0000_0034, 0};
      v[5] = '{1'b1, 32'h0000_0FFC, 32'hDEADBEEF,  4'hf, 1'b1, 1'b0, 32'h0000_0FE8, 1};
      v[6] = '{1'b1, 32'h0000_1004, 32'h1234,      4'hf, 1'b0, 1'b1, 32'h0000_1010, 0};
      v[7] = '{1'b0, 32'h0000_0ABC, 32'h0,         4'hf, 1'b1, 1'b0, 32'h0000_0AA8, 0};

      #3;
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_dat", dato, 32'h0);
      chk("rst_rty", {31'h0, rty}, 32'h0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         classic(v[i].we, v[i].adr, v[i].dat, v[i].sel, v[i].ack, v[i].err, v[i].rd, v[i].nwr);

      ea[0] = 16'h0200; ea[1] = 16'h0204; ea[2] = 16'h0208; ea[3] = 16'h020C;
      burst(2'b00, 4, -1);
      ea[0] = 16'h0208; ea[1] = 16'h020C; ea[2] = 16'h0200; ea[3] = 16'h0204;
      burst(2'b01, 4, 1);
      ea[0] = 16'h031C; ea[1] = 16'h0300; ea[2] = 16'h0304;
      burst(2'b10, 3, -1);
      ea[0] = 16'hFFF8; ea[1] = 16'hFFFC; ea[2] = 16'h0000;
      burst(2'b00, 3, -1);
      ea[0] = 16'h043C; ea[1] = 16'h0400;
      burst(2'b11, 2, -1);

      // Asynchronous reset while beat 2 of a burst is being acknowledged.
      cyc = 1; stb = 1; we = 0; sel = 4'hf; bte = 2'b00; cti = 3'b010; adr = 32'h200;
      exp_q.push_back(rsp_t'{1'b1, 1'b0, 32'h214});
      @(posedge clk); #1;
      adr = 32'h204;
      chk("rst_burst_adr", {16'h0, cadr}, 32'h204);
      @(posedge clk); #2;
      rst = 0; cyc = 0; stb = 0;
      #1;
      chk("midrst_ack", {31'h0, ack}, 32'h0);
      chk("midrst_err", {31'h0, err}, 32'h0);
      chk("midrst_dat", dato, 32'h0);
      chk("midrst_we", {31'h0, cwe}, 32'h0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1;
      classic(v[0].we, v[0].adr, v[0].dat, v[0].sel, v[0].ack, v[0].err, v[0].rd, v[0].nwr);

      chk("queue_empty", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
